// File: rtl/matriz_unaria_seq.sv
// Sequential unary matrix unit: negation, transpose, saturating scalar multiply or copy,
// applied one element per clock to a captured square matrix of size 2..MAX_DIM.
module matriz_unaria_seq #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [1:0]                        op,
  input  logic [1:0]                        matrix_size,
  input  logic [DATA_W-1:0]                 scalar,
  input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_A,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0] result,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
);

  localparam int NE    = MAX_DIM * MAX_DIM;
  localparam int BUS_W = NE * DATA_W;
  localparam int CNT_W = $clog2(MAX_DIM + 1);
  localparam int IDX_W = $clog2(NE);

  localparam logic signed [DATA_W-1:0]   ELEM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0]   ELEM_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [2*DATA_W-1:0] PROD_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] PROD_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 op_q, op_d;
  logic [CNT_W-1:0]           n_q, n_d;
  logic [CNT_W-1:0]           r_q, r_d;
  logic [CNT_W-1:0]           c_q, c_d;
  logic signed [DATA_W-1:0]   scal_q, scal_d;
  logic [BUS_W-1:0]           mat_q, mat_d;
  logic                       ovf_q, ovf_d;

  int                         n_req;
  int                         src_int;
  int                         dst_int;
  logic [CNT_W-1:0]           n_in;
  logic [CNT_W-1:0]           last;
  logic [IDX_W-1:0]           src_idx;
  logic [IDX_W-1:0]           dst_idx;
  logic signed [DATA_W-1:0]   a_elem [NE];
  logic signed [DATA_W-1:0]   x;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   res_val;
  logic                       ovf_elem;

  // Requested dimension is size+2; anything beyond MAX_DIM is clamped.
  always_comb begin
    n_req = int'(matrix_size) + 2;
    if (n_req > MAX_DIM) begin
      n_in = CNT_W'(MAX_DIM);
    end else begin
      n_in = CNT_W'(n_req);
    end
  end

  assign last = n_q - CNT_W'(1);

  always_comb begin
    src_int = int'(r_q) * int'(n_q) + int'(c_q);
    if (op_q == 2'b01) begin
      dst_int = int'(c_q) * int'(n_q) + int'(r_q);
    end else begin
      dst_int = src_int;
    end
    src_idx = IDX_W'(src_int);
    dst_idx = IDX_W'(dst_int);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NE; gi++) begin : g_elem
      assign a_elem[gi] = mat_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign x    = a_elem[src_idx];
  assign prod = {{DATA_W{x[DATA_W-1]}}, x} * {{DATA_W{scal_q[DATA_W-1]}}, scal_q};

  always_comb begin
    res_val  = x;
    ovf_elem = 1'b0;
    case (op_q)
      2'b00: begin
        if (x == ELEM_MIN) begin
          res_val  = ELEM_MAX;
          ovf_elem = 1'b1;
        end else begin
          res_val = -x;
        end
      end
      2'b10: begin
        if (prod > PROD_MAX) begin
          res_val  = ELEM_MAX;
          ovf_elem = 1'b1;
        end else if (prod < PROD_MIN) begin
          res_val  = ELEM_MIN;
          ovf_elem = 1'b1;
        end else begin
          res_val = prod[DATA_W-1:0];
        end
      end
      default: begin
        res_val  = x;
        ovf_elem = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    n_d     = n_q;
    r_d     = r_q;
    c_d     = c_q;
    scal_d  = scal_q;
    mat_d   = mat_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        op_d    = op;
        n_d     = n_in;
        scal_d  = scalar;
        mat_d   = matrix_A;
        r_d     = '0;
        c_d     = '0;
        ovf_d   = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        ovf_d = ovf_q | ovf_elem;
        if (c_q == last) begin
          c_d = '0;
          if (r_q == last) begin
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            r_d = r_q + CNT_W'(1);
          end
        end else begin
          c_d = c_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      n_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      scal_q  <= '0;
      mat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n_q     <= n_d;
      r_q     <= r_d;
      c_q     <= c_d;
      scal_q  <= scal_d;
      mat_q   <= mat_d;
      ovf_q   <= ovf_d;
    end
  end

  // Each result element only ever takes a write from its own destination slot.
  generate
    for (gi = 0; gi < NE; gi++) begin : g_res
      logic signed [DATA_W-1:0] res_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else if (state_q == S_LOAD) begin
          res_q <= '0;
        end else if ((state_q == S_RUN) && (dst_idx == IDX_W'(gi))) begin
          res_q <= res_val;
        end
      end
      assign result[gi*DATA_W +: DATA_W] = res_q;
    end
  endgenerate

  assign busy     = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_matriz_unaria_seq.sv
// Directed bench for matriz_unaria_seq: reset, each opcode, saturation, latency,
// start filtering during an operation and asynchronous reset mid-operation.
module tb_matriz_unaria_seq;

  localparam int DW = 8;
  localparam int MD = 5;
  localparam int NE = MD * MD;
  localparam int BW = NE * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [1:0]    matrix_size;
  logic [DW-1:0] scalar;
  logic [BW-1:0] matrix_A;
  logic [BW-1:0] result;
  logic          busy;
  logic          done;
  logic          overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  matriz_unaria_seq #(.DATA_W(DW), .MAX_DIM(MD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .matrix_size(matrix_size),
    .scalar     (scalar),
    .matrix_A   (matrix_A),
    .result     (result),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] put(input logic [BW-1:0] v, input int idx, input int val);
    logic [BW-1:0] t;
    t = v;
    t[idx*DW +: DW] = DW'(val);
    return t;
  endfunction

  // Launch one operation and wait (bounded) for done. lat counts cycles from the
  // accepting edge to the end of the done cycle, so n=2 gives 6 and n=5 gives 27.
  task automatic run_op(input logic [1:0] op_v, input logic [1:0] size_v, input logic [DW-1:0] sc_v,
                        input logic [BW-1:0] a_v, input bit chk_busy, input bit disturb, output int lat);
    int k;
    @(negedge clk);
    op          = op_v;
    matrix_size = size_v;
    scalar      = sc_v;
    matrix_A    = a_v;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    k     = 0;
    lat   = -1;
    while (k < 80) begin
      if (done) begin
        lat = k + 1;
        break;
      end
      if (chk_busy) check_val("busy_during_op", {199'd0, busy}, {199'd0, 1'b1});
      if (disturb && k >= 3 && k <= 5) begin
        start    = 1'b1;
        op       = 2'b00;
        matrix_A = ~a_v;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    $display("[TB] op=%0d size=%0d scalar=%0d latency=%0d overflow=%0b", op_v, size_v, $signed(sc_v), lat, overflow);
  endtask

  initial begin
    logic [BW-1:0] a;
    logic [BW-1:0] e;
    int lat;
    int dones;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; matrix_size = 2'b00; scalar = '0; matrix_A = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    matrix_A = '1;
    repeat (8) @(negedge clk);
    check_val("idle_result",   result,              '0);
    check_val("idle_busy",     {199'd0, busy},      '0);
    check_val("idle_done",     {199'd0, done},      '0);
    check_val("idle_overflow", {199'd0, overflow},  '0);

    // Negate 2x2; idx4 is outside the active region and must stay zero.
    a = '0;
    a = put(a, 0, 1); a = put(a, 1, -2); a = put(a, 2, 3); a = put(a, 3, 127); a = put(a, 4, 55);
    e = '0;
    e = put(e, 0, -1); e = put(e, 1, 2); e = put(e, 2, -3); e = put(e, 3, -127);
    run_op(2'b00, 2'b00, 8'd0, a, 1'b1, 1'b0, lat);
    check_val("neg2_latency",  lat, 6);
    check_val("neg2_result",   result, e);
    check_val("neg2_overflow", {199'd0, overflow}, '0);
    check_val("neg2_busy_at_done", {199'd0, busy}, '0);
    @(negedge clk);
    check_val("neg2_done_pulse", {199'd0, done}, '0);

    // Negate 3x3 with -128 in the centre.
    a = '0; e = '0;
    for (int k = 0; k < 9; k++) begin
      a = put(a, k, k);
      e = put(e, k, -k);
    end
    a = put(a, 4, -128);
    e = put(e, 4, 127);
    run_op(2'b00, 2'b01, 8'd0, a, 1'b0, 1'b0, lat);
    check_val("neg3_latency",  lat, 11);
    check_val("neg3_result",   result, e);
    check_val("neg3_overflow", {199'd0, overflow}, {199'd0, 1'b1});

    // Scalar 16 on all-10 3x3 clips every element.
    a = '0; e = '0;
    for (int k = 0; k < 9; k++) begin
      a = put(a, k, 10);
      e = put(e, k, 127);
    end
    run_op(2'b10, 2'b01, 8'd16, a, 1'b0, 1'b0, lat);
    check_val("mul16_result",   result, e);
    check_val("mul16_overflow", {199'd0, overflow}, {199'd0, 1'b1});

    // Copy of the same matrix: overflow cleared at LOAD.
    run_op(2'b11, 2'b01, 8'd16, a, 1'b0, 1'b0, lat);
    check_val("copy_result",   result, a);
    check_val("copy_overflow", {199'd0, overflow}, '0);

    // Scalar -3: in-range values plus clipping in both directions.
    a = '0; e = '0;
    a = put(a, 0, 5);   a = put(a, 1, -5); a = put(a, 2, -43); a = put(a, 3, 43);
    e = put(e, 0, -15); e = put(e, 1, 15); e = put(e, 2, 127);  e = put(e, 3, -128);
    run_op(2'b10, 2'b00, -8'sd3, a, 1'b0, 1'b0, lat);
    check_val("mulneg_result",   result, e);
    check_val("mulneg_overflow", {199'd0, overflow}, {199'd0, 1'b1});

    // Transpose 5x5.
    a = '0; e = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        a = put(a, r*5 + c, r*5 + c);
        e = put(e, c*5 + r, r*5 + c);
      end
    end
    run_op(2'b01, 2'b11, 8'd0, a, 1'b0, 1'b0, lat);
    check_val("tr5_latency",  lat, 27);
    check_val("tr5_idx1",     {192'd0, result[1*DW +: DW]}, 200'd5);
    check_val("tr5_idx5",     {192'd0, result[5*DW +: DW]}, 200'd1);
    check_val("tr5_result",   result, e);
    check_val("tr5_overflow", {199'd0, overflow}, '0);

    // Transpose 3x3 while start, op and matrix_A are disturbed mid-run.
    a = '0; e = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        a = put(a, r*3 + c, r*3 + c + 1);
        e = put(e, c*3 + r, r*3 + c + 1);
      end
    end
    run_op(2'b01, 2'b01, 8'd0, a, 1'b0, 1'b1, lat);
    check_val("hs_latency", lat, 11);
    check_val("hs_result",  result, e);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_val("hs_no_restart", dones, 0);
    check_val("hs_result_stable", result, e);

    // Asynchronous reset in the middle of a 5x5 copy.
    a = '0;
    for (int k = 0; k < 25; k++) a = put(a, k, k + 1);
    @(negedge clk);
    op = 2'b11; matrix_size = 2'b11; matrix_A = a; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check_val("rst_mid_busy_before", {199'd0, busy}, {199'd0, 1'b1});
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_result", result, '0);
    check_val("rst_mid_busy",   {199'd0, busy}, '0);
    check_val("rst_mid_done",   {199'd0, done}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    a = '0;
    a = put(a, 0, 1); a = put(a, 1, -2); a = put(a, 2, 3); a = put(a, 3, 127);
    e = '0;
    e = put(e, 0, -1); e = put(e, 1, 2); e = put(e, 2, -3); e = put(e, 3, -127);
    run_op(2'b00, 2'b00, 8'd0, a, 1'b0, 1'b0, lat);
    check_val("post_rst_latency", lat, 6);
    check_val("post_rst_result",  result, e);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/matriz_unaria_seq.md
Name: matriz_unaria_seq

Overview:
- Sequential, parametrised successor to the combinational matrix-negation unit in the matrix coprocessor datapath.
- Accepts one packed square matrix (2x2 up to MAX_DIM x MAX_DIM) and a unary opcode: negation, transpose, scalar multiply or copy.
- Processes one element per clock under a start/busy/done handshake and saturates results instead of wrapping.
- Sits between the operand register bank and the result bus, beside the other matrix operation units.

Parameters:
DATA_W, 8, signed element width in bits.
MAX_DIM, 5, maximum matrix dimension; bus holds MAX_DIM*MAX_DIM elements.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  operation request; sampled only in IDLE.
op  input  2  00 negation, 01 transpose, 10 scalar multiply, 11 copy.
matrix_size  input  2  n = matrix_size+2 (2..5); n clamped to MAX_DIM if larger.
scalar  input  DATA_W  signed multiplier for op 10.
matrix_A  input  MAX_DIM*MAX_DIM*DATA_W  packed signed operand; element (r,c) at index r*n+c, bits [idx*DATA_W +: DATA_W].
result  output  MAX_DIM*MAX_DIM*DATA_W  packed result, same layout; registered.
busy  output  1  high in LOAD and RUN.
done  output  1  one-cycle pulse when result is final.
overflow  output  1  sticky saturation flag for the current/last operation.

Behaviour:
- Reset (rst_n low, any time, including mid-operation): state IDLE; result all zeros; busy 0; done 0; overflow 0; counters 0. Takes effect immediately, not at the next edge.
- FSM states: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE: start=1 at edge T moves the FSM to LOAD.
- LOAD (one cycle):
  - Captures matrix_A, op, n and scalar into internal registers; later input changes have no effect.
  - Clears result to zero and clears overflow.
  - Resets row counter r and column counter c to 0.
- RUN: n*n cycles, one element per cycle.
  - Source index is r*n+c.
  - Destination index is c*n+r for transpose, r*n+c for all other ops.
  - c increments and wraps at n-1 to 0, incrementing r. Leave RUN after r=n-1, c=n-1.
- DONE (one cycle): done=1, busy=0; then IDLE.
- Handshake and timing:
  - start is ignored in LOAD, RUN and DONE; it is not queued.
  - done rises 2+n*n cycles after the accepting edge (n=2: 6 cycles; n=5: 27 cycles).
  - result is stable from the done pulse until the next LOAD.
- Arithmetic, all signed:
  - Negation: -x; x = -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1 and sets overflow.
  - Scalar multiply: full 2*DATA_W product, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; any clip sets overflow.
  - Transpose and copy: pass the value unchanged; they never set overflow.
- Inactive element positions (index >= n*n) stay zero in result.
- overflow is sticky from the first saturating element until the next LOAD or reset.

Test Plan:
- Reset then idle: hold rst_n=0, then release with start=0 -> result=0, busy=0, done=0, overflow=0 indefinitely.
- Negate 2x2: A={1,-2,3,127} (idx0..3), op=00, size=00 -> done at T+6; result idx0..3={-1,2,-3,-127}; idx4..24=0; overflow=0; busy high T+1..T+5.
- Saturation: 3x3 op=00 with idx4=-128 -> result idx4=127, overflow=1. Then scalar op=10, scalar=16, all elements 10 -> every element 127, overflow=1. Then op=11 on the same matrix -> overflow clears at LOAD and stays 0.
- Transpose 5x5: A idx(r*5+c)=r*5+c, op=01, size=11 -> result idx(c*5+r)=r*5+c (e.g. idx1=5, idx5=1); done at T+27.
- Handshake: pulse start during RUN with different op/matrix_A, and change matrix_A mid-RUN -> no restart; result matches the captured operands; a single done pulse.
- Reset mid-RUN: rst_n low during cycle T+10 of a 5x5 op -> result=0, busy=0 immediately; after release, a new start completes normally.
